tap_host_driver: RTL and testbench

TAP_HOST_DRIVER -- requirements
Module: tap_host_driver

---
 rtl/tap_host_pkg.sv | 20 ++
 rtl/tck_phase_gen.sv | 25 ++
 rtl/tap_host_driver.sv | 115 +++++++++++
 tb/tb_tap_host_driver.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tap_host_pkg.sv
// Shared TAP host definitions: frame widths and host FSM states.
// Used by the host driver and the target-side decoder/encoder.
package tap_host_pkg;

  localparam int TAP_DATA_WIDTH   = 8;
  localparam int TAP_RESULT_WIDTH = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    RESPOND = 3'd4
  } tap_host_state_t;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tck_phase_gen.sv
// TAP clock generator: tck = clk/2, held low for one clk after reset.
// tck_fall is high while the next clk edge drives tck low.
module tck_phase_gen (
  input  logic clk,
  input  logic reset,
  output logic tck,
  output logic tck_fall
);

  logic run;

  // Start toggling one clk after reset so ready cannot rise on edge 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= 1'b0;
      tck <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) tck <= ~tck;
    end
  end

  assign tck_fall = tck;

endmodule

// File: rtl/tap_host_driver.sv
// TAP host driver: runs CAPTURE/SHIFT/UPDATE data-register frames
// for write and read commands, returning read results on rsp.
module tap_host_driver
  import tap_host_pkg::*;
#(
  parameter int DATA_WIDTH   = TAP_DATA_WIDTH,
  parameter int RESULT_WIDTH = TAP_RESULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_read,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  output logic                    tck,
  output logic                    tdi,
  input  logic                    tdo,
  output logic                    ir_is_user,
  output logic                    capture_dr,
  output logic                    shift_dr,
  output logic                    update_dr,
  output logic                    rsp_valid,
  output logic [RESULT_WIDTH-1:0] rsp_data
);

  localparam int MAXW = max_int(DATA_WIDTH, RESULT_WIDTH);
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

  localparam logic [CW-1:0] W_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] R_LAST = CW'(RESULT_WIDTH - 1);

  tap_host_state_t         state;
  logic                    rd_q;
  logic [DATA_WIDTH-1:0]   dsr;
  logic [RESULT_WIDTH-1:0] rsr;
  logic [CW-1:0]           cnt;
  logic                    tck_fall;
  logic                    at_last;

  tck_phase_gen u_phase (
    .clk      (clk),
    .reset    (reset),
    .tck      (tck),
    .tck_fall (tck_fall)
  );

  assign cmd_ready = (state == IDLE) && tck_fall;
  assign at_last   = (cnt == (rd_q ? R_LAST : W_LAST));

  // Frame sequencer; TAP-visible outputs move only on tck-low edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rd_q       <= 1'b0;
      dsr        <= '0;
      rsr        <= '0;
      cnt        <= '0;
      tdi        <= 1'b0;
      ir_is_user <= 1'b0;
      capture_dr <= 1'b0;
      shift_dr   <= 1'b0;
      update_dr  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
    end else begin
      ir_is_user <= 1'b1;
      rsp_valid  <= 1'b0;
      if (state == RESPOND) begin
        rsp_valid <= 1'b1;
        rsp_data  <= rsr;
        state     <= IDLE;
      end else if (tck_fall) begin
        unique case (state)
          IDLE: begin
            if (cmd_valid) begin
              rd_q       <= cmd_read;
              dsr        <= cmd_read ? '0 : cmd_data;
              capture_dr <= 1'b1;
              tdi        <= 1'b0;
              state      <= CAPTURE;
            end
          end
          CAPTURE: begin
            capture_dr <= 1'b0;
            shift_dr   <= 1'b1;
            cnt        <= '0;
            tdi        <= dsr[0];
            dsr        <= dsr >> 1;
            state      <= SHIFT;
          end
          SHIFT: begin
            if (rd_q) rsr <= {tdo, rsr[RESULT_WIDTH-1:1]};
            if (at_last) begin
              shift_dr  <= 1'b0;
              update_dr <= 1'b1;
              tdi       <= 1'b0;
              cnt       <= '0;
              state     <= UPDATE;
            end else begin
              cnt <= cnt + 1'b1;
              tdi <= dsr[0];
              dsr <= dsr >> 1;
            end
          end
          UPDATE: begin
            update_dr <= 1'b0;
            state     <= rd_q ? RESPOND : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tap_host_driver.sv
// Randomized scoreboard bench for tap_host_driver with a
// behavioural TAP target and frame-timing reference model.
module tb_tap_host_driver;

  localparam int DW = 8;
  localparam int RW = 10;

  typedef struct {
    bit            rd;
    logic [DW-1:0] d;
    logic [RW-1:0] r;
    int            acc;
  } frame_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_read = 1'b0;
  logic [DW-1:0] cmd_data = '0;
  logic          tck, tdi;
  logic          tdo = 1'b0;
  logic          ir_is_user, capture_dr, shift_dr, update_dr;
  logic          rsp_valid;
  logic [RW-1:0] rsp_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc;
  int earliest;

  frame_t frame_q[$];
  frame_t cur;
  bit     in_frame = 0;
  int     bitn;
  logic [15:0] wbuf;
  logic [15:0] rres;
  logic [4:0]  prev;

  tap_host_driver #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_read   (cmd_read),
    .cmd_data   (cmd_data),
    .tck        (tck),
    .tdi        (tdi),
    .tdo        (tdo),
    .ir_is_user (ir_is_user),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Target model and per-clk protocol monitor
  always @(negedge clk) begin
    if (reset) begin
      in_frame = 0;
      tdo = 1'b0;
      prev = {tdi, capture_dr, shift_dr, update_dr, ir_is_user};
    end else begin
      check("strobe_onehot",
            32'($countones({capture_dr, shift_dr, update_dr}) <= 1), 1);
      if ({tdi, capture_dr, shift_dr, update_dr, ir_is_user} != prev)
        check("change_on_tck_low_edge", 32'(tck), 0);
      prev = {tdi, capture_dr, shift_dr, update_dr, ir_is_user};
      if (tck && capture_dr) begin
        if (frame_q.size() == 0) begin
          check("capture_without_cmd", 0, 1);
        end else begin
          cur = frame_q.pop_front();
          in_frame = 1;
          bitn = 0;
          wbuf = '0;
          rres = 16'(cur.r);
        end
      end
      if (tck && shift_dr && in_frame) begin
        if (bitn < 16) begin
          wbuf[bitn] = tdi;
          tdo = rres[bitn];
        end
        bitn++;
      end
      if (tck && update_dr) begin
        if (!in_frame) begin
          check("stray_update", 0, 1);
        end else begin
          check("shift_len", 32'(bitn), cur.rd ? RW : DW);
          check(cur.rd ? "read_tdi_zero" : "write_word",
                32'(wbuf), cur.rd ? 0 : 32'(cur.d));
          if (!cur.rd) in_frame = 0;
        end
      end
      if (rsp_valid) begin
        if (!(in_frame && cur.rd)) begin
          check("stray_rsp", 0, 1);
        end else begin
          check("rsp_data", 32'(rsp_data), 32'(cur.r));
          check("rsp_latency", 32'(cyc - cur.acc), 25);
          in_frame = 0;
        end
      end
    end
  end

  task automatic do_cmd(input bit rd, input logic [DW-1:0] d,
                        input logic [RW-1:0] r, input int gap);
    int p, pe, n, ae;
    frame_t f;
    repeat (gap) @(negedge clk);
    p  = cyc + 1;
    pe = (p > earliest) ? p : earliest;
    if (pe % 2 == 0) pe++;
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_data  = d;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      ae = cyc + 1;
      check("accept_edge", 32'(ae), 32'(pe));
      f.rd = rd; f.d = d; f.r = r; f.acc = ae;
      frame_q.push_back(f);
      earliest = ae + (rd ? 26 : 22);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = DW'($urandom);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    earliest = 3;
    @(negedge clk);
    check("ready_low_edge1", 32'(cmd_ready), 0);
    check("ir_user_edge1", 32'(ir_is_user), 1);
    @(negedge clk);
    check("ready_high_edge2", 32'(cmd_ready), 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 32'({tck, tdi, ir_is_user, capture_dr, shift_dr,
                     update_dr, cmd_ready, rsp_valid, rsp_data}), 0);
  endtask

  initial begin
    earliest = 3;
    #1;
    check_reset_outputs("reset_outputs");
    release_reset();

    do_cmd(0, 8'h41, '0, 0);
    do_cmd(1, '0, 10'h2A5, 0);
    do_cmd(0, 8'h31, '0, 0);
    do_cmd(0, 8'h0A, '0, 0);
    do_cmd(1, '0, 10'h3FF, 0);
    do_cmd(1, '0, 10'h000, 0);
    do_cmd(0, 8'hFF, '0, 3);

    do_cmd(0, 8'hFF, '0, 5);
    repeat (7) @(negedge clk);
    check("shift_before_abort", 32'(shift_dr), 1);
    reset = 1'b1;
    frame_q.delete();
    #1;
    check_reset_outputs("abort_outputs");
    release_reset();

    do_cmd(0, 8'h00, '0, 0);
    do_cmd(0, 8'hFF, '0, 0);

    for (int i = 0; i < 40; i++) begin
      do_cmd(bit'($urandom_range(0, 1)), DW'($urandom), RW'($urandom),
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : 0);
    end

    repeat (60) @(negedge clk);
    check("drain", 32'(frame_q.size() == 0 && !in_frame), 1);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
